// File: rtl/dec24_if.sv
// Decoder bus: enable and binary index toward the decoder, registered one-hot back.
interface dec24_if #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 2 ** IN_W
);
  logic             EN;
  logic [IN_W-1:0]  IN;
  logic [OUT_W-1:0] OUT;

  modport master (output EN, output IN, input OUT);
  modport slave  (input EN, input IN, output OUT);
endinterface

// File: rtl/dec24.sv
// Registered 2-to-4 line decoder with active-high enable and async active-high reset.
module dec24 #(
  parameter int IN_W  = 2,
  parameter int OUT_W = 2 ** IN_W
) (
  input  logic   CLK,
  input  logic   RST,
  dec24_if.slave bus
);
  logic [OUT_W-1:0] dec;

  // X/Z on EN or IN fails every equality test, so unknowns decode to all-zero.
  always_comb begin
    dec = '0;
    if (bus.EN == 1'b1) begin
      for (int unsigned k = 0; k < OUT_W; k++) begin
        if (bus.IN == IN_W'(k)) dec[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) bus.OUT <= '0;
    else     bus.OUT <= dec;
  end
endmodule

// File: tb/tb_dec24.sv
// Self-checking bench for dec24: vector table, corner sequences, randomized model check.
module tb_dec24;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dec24_if #(.IN_W(2)) bus ();
  dec24 #(.IN_W(2)) dut (.CLK(clk), .RST(rst), .bus(bus));

  typedef struct {
    logic       en;
    logic [1:0] in;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_onehot(input string name, input logic [3:0] act);
    checks++;
    if ($isunknown(act) || $countones(act) > 1) begin
      failures++;
      $display("FAIL %s: got %b expected zero or one-hot at %0t", name, act, $time);
    end
  endtask

  // Drive inputs away from the edge, then sample just after the rising edge.
  task automatic cycle(input logic en, input logic [1:0] in);
    @(negedge clk);
    bus.EN = en;
    bus.IN = in;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] model(input logic en, input logic [1:0] in);
    int v;
    v = en ? 2 ** int'(in) : 0;
    return v[3:0];
  endfunction

  initial begin
    vecs[0] = '{1'b0, 2'd0, 4'b0000};
    vecs[1] = '{1'b0, 2'd1, 4'b0000};
    vecs[2] = '{1'b0, 2'd2, 4'b0000};
    vecs[3] = '{1'b0, 2'd3, 4'b0000};
    vecs[4] = '{1'b1, 2'd0, 4'b0001};
    vecs[5] = '{1'b1, 2'd1, 4'b0010};
    vecs[6] = '{1'b1, 2'd2, 4'b0100};
    vecs[7] = '{1'b1, 2'd3, 4'b1000};
    vecs[8] = '{1'b1, 2'd2, 4'b0100};
    vecs[9] = '{1'b0, 2'd2, 4'b0000};

    // Reset held with decode-worthy inputs and a running clock
    rst    = 1'b1;
    bus.EN = 1'b1;
    bus.IN = 2'd3;
    #1;
    check("reset_async", bus.OUT, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", bus.OUT, 4'b0000);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      cycle(vecs[i].en, vecs[i].in);
      check($sformatf("vec%0d", i), bus.OUT, vecs[i].exp);
    end

    // Mid-operation reset pulse between edges
    cycle(1'b1, 2'd1);
    check("mid_pre", bus.OUT, 4'b0010);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("mid_async_clear", bus.OUT, 4'b0000);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 check("mid_resume", bus.OUT, 4'b0010);

    // Reset coincident with a clock edge wins
    cycle(1'b1, 2'd2);
    check("coinc_pre", bus.OUT, 4'b0100);
    @(posedge clk);
    rst = 1'b1;
    #1 check("coinc_clear", bus.OUT, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("coinc_resume", bus.OUT, 4'b0100);

    // Latency: a mid-cycle IN change must not reach OUT before the edge
    cycle(1'b1, 2'd0);
    check("lat_first", bus.OUT, 4'b0001);
    @(negedge clk);
    bus.IN = 2'd3;
    #1 check("lat_hold", bus.OUT, 4'b0001);
    @(posedge clk);
    #1 check("lat_update", bus.OUT, 4'b1000);

    // Randomized against the arithmetic model, with occasional async reset pulses
    for (int i = 0; i < 300; i++) begin
      logic       en;
      logic [1:0] in;
      en = 1'($urandom_range(0, 1));
      in = 2'($urandom_range(0, 3));
      cycle(en, in);
      check("rand", bus.OUT, model(en, in));
      check_onehot("rand_onehot", bus.OUT);
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check("rand_reset", bus.OUT, 4'b0000);
        rst = 1'b0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
